nf10_rx_timestamp: RTL and testbench
====================================

Name: nf10_rx_timestamp

Overview:
- Ingress stage directly upstream of nf10_packet_cutter in the monitor datapath.
- Accepts 256-bit AXI-Stream packets and writes a 64-bit arrival timestamp into TUSER on each packet's first beat.
- Passes all other fields through unchanged to the cutter's S_AXIS input.
- Output is fully registered: one-deep pipeline plus a skid register, sustaining 1 beat/cycle.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width; tstrb width = C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, tuser width.
- TS_LSB, 32, lowest tuser bit of the 64-bit timestamp field (field is [TS_LSB+63:TS_LSB]); must satisfy TS_LSB+63 < C_AXIS_TUSER_WIDTH.
- TS_INC, 32'h0000_0005, amount added to the timestamp counter each cycle (5 ns at 200 MHz).

Ports:
- axi_aclk  in  1  clock.
- axi_resetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  C_AXIS_DATA_WIDTH  ingress data.
- s_axis_tstrb  in  C_AXIS_DATA_WIDTH/8  ingress byte strobes.
- s_axis_tuser  in  C_AXIS_TUSER_WIDTH  ingress metadata.
- s_axis_tvalid  in  1  ingress valid.
- s_axis_tready  out  1  ingress ready.
- s_axis_tlast  in  1  ingress end of packet.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  egress data.
- m_axis_tstrb  out  C_AXIS_DATA_WIDTH/8  egress strobes.
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  egress metadata with timestamp inserted.
- m_axis_tvalid  out  1  egress valid.
- m_axis_tready  in  1  egress ready.
- m_axis_tlast  out  1  egress end of packet.
- ts_load  in  1  one-cycle pulse: load the timestamp counter.
- ts_load_value  in  64  value loaded on ts_load.
- ts_now  out  64  current timestamp counter value.
- pkt_count  out  32  count of packets accepted on the ingress.

Behaviour:
- Reset values: m_axis_tvalid=0, s_axis_tready=0 while axi_resetn=0 and 1 in the first cycle after release; all m_axis data outputs=0; ts_now=0; pkt_count=0; sop=1; skid empty.
- Timestamp counter:
  - Increments each cycle: ts <= ts + TS_INC, modulo 2^64; wraps from FFFF_FFFF_FFFF_FFFE to 3 with TS_INC=5.
  - ts_load has priority over the increment: ts <= ts_load_value, and ts_now shows that value the next cycle.
- Ingress handshake: a beat is accepted when s_axis_tvalid && s_axis_tready. s_axis_tready = !skid_valid, taken directly from a register.
- SOP tracking:
  - The sop register is set at reset and after an accepted beat with tlast=1; it is cleared after an accepted beat with tlast=0.
  - A single-beat packet (sop and tlast on the same beat) leaves sop=1.
- Stamping:
  - On an accepted beat with sop=1, the tuser field [TS_LSB+63:TS_LSB] is replaced with ts_now as sampled in the acceptance cycle.
  - All other tuser bits pass through unchanged.
  - Non-first beats pass tuser through unmodified.
- Output pipeline: an output register plus one skid register.
  - Latency 1 cycle from acceptance to m_axis_tvalid when the egress is not stalled.
  - When the output register is full and m_axis_tready=0, an accepted beat goes into the skid register and s_axis_tready drops the next cycle.
  - When m_axis_tready=1 the skid drains into the output register first; skid order is preserved.
  - Outputs are held stable while m_axis_tvalid=1 and m_axis_tready=0.
  - No beat is dropped or duplicated.
- pkt_count increments by 1 on each accepted tlast beat; it wraps 32'hFFFF_FFFF -> 0.
- Simultaneous ts_load and first-beat acceptance: the beat carries the pre-load ts_now.
- Reset mid-packet: the partial packet is discarded and sop=1. The first beat accepted after reset is treated as SOP and stamped.

Optional Feature:
- Macro RX_TS_DELTA_EN.
- Defined:
  - An extra 32-bit register holds the inter-arrival delta: ts at this SOP minus ts at the previous SOP, low 32 bits, modulo 2^32.
  - The delta is written into tuser[TS_LSB+95:TS_LSB+64] on first beats. Elaboration requires TS_LSB+95 < C_AXIS_TUSER_WIDTH.
  - The first packet after reset or after ts_load carries delta 0.
- Undefined: no delta logic exists, and those tuser bits pass through unchanged.

Test Plan:
- Reset then ts_load=1 with ts_load_value=64'h100, followed by a 4-beat packet with s_axis_tuser=128'h02010080 accepted at ts_now=64'h10A -> beat 0 m_axis_tuser=128'h0000_0000_0000_0000_0000_010A_0201_0080; beats 1-3 tuser=128'h02010080; pkt_count=1.
- Back-to-back 1-beat packets on consecutive cycles with m_axis_tready=1 -> each stamped; stamps differ by 5; sustained 1 beat/cycle; pkt_count increments each cycle.
- Hold m_axis_tready=0 for 3 cycles mid-packet -> s_axis_tready=0 after the skid fills; tdata order is intact with no loss or duplicate once m_axis_tready returns to 1.
- Load 64'hFFFF_FFFF_FFFF_FFFA -> ts_now reads ...FFFF, then 64'h4 on the following cycle.
- Assert axi_resetn=0 after beat 2 of a 5-beat packet -> m_axis_tvalid=0 immediately; the next packet's first beat after release is stamped.
- With RX_TS_DELTA_EN defined, send SOPs 20 cycles apart -> the second packet's delta field = 32'd100 and the first packet's delta field = 0.

Source files
------------

// File: rtl/nf10_rx_timestamp.sv
// nf10_rx_timestamp
// Ingress stage that sits directly in front of nf10_packet_cutter. It accepts
// 256-bit AXI-Stream beats and writes a free-running 64-bit arrival timestamp
// into TUSER on the first beat of every packet. Every other field passes
// through untouched. The egress side is fully registered: one output register
// backed by one skid register, so the stage sustains one beat per cycle while
// s_axis_tready still comes straight from a flop.
//
// Optional feature, enabled by defining RX_TS_DELTA_EN:
//   First beats also carry the low 32 bits of the inter-arrival delta
//   (timestamp at this SOP minus timestamp at the previous SOP) in
//   tuser[TS_LSB+95:TS_LSB+64]. The first packet after reset or after a
//   timestamp load carries a delta of zero. Without the macro no delta logic
//   is built and those tuser bits pass through unchanged.

module nf10_rx_timestamp #(
    parameter int          C_AXIS_DATA_WIDTH  = 256,
    parameter int          C_AXIS_TUSER_WIDTH = 128,
    parameter int          TS_LSB             = 32,
    parameter logic [31:0] TS_INC             = 32'h0000_0005
) (
    input  logic                              axi_aclk,
    input  logic                              axi_resetn,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,

    output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,

    input  logic                              ts_load,
    input  logic [63:0]                       ts_load_value,
    output logic [63:0]                       ts_now,
    output logic [31:0]                       pkt_count
);

    localparam int StrbWidth = C_AXIS_DATA_WIDTH / 8;

    // The timestamp field has to fit inside tuser; refuse to elaborate otherwise.
    if (TS_LSB + 63 >= C_AXIS_TUSER_WIDTH) begin : gTsFieldCheck
        $error("nf10_rx_timestamp: TS_LSB+63 must be below C_AXIS_TUSER_WIDTH");
    end

`ifdef RX_TS_DELTA_EN
    // The delta field sits directly above the timestamp and must fit as well.
    if (TS_LSB + 95 >= C_AXIS_TUSER_WIDTH) begin : gDeltaFieldCheck
        $error("nf10_rx_timestamp: TS_LSB+95 must be below C_AXIS_TUSER_WIDTH");
    end
`endif

    // One AXI-Stream beat as it travels through the output/skid registers.
    typedef struct packed {
        logic [C_AXIS_DATA_WIDTH-1:0]  data;
        logic [StrbWidth-1:0]          strb;
        logic [C_AXIS_TUSER_WIDTH-1:0] user;
        logic                          last;
    } beat_t;

    // Timestamp counter and packet counter.
    logic [63:0] tsCount_q;
    logic [63:0] tsCount_d;
    logic [31:0] pktCount_q;
    logic [31:0] pktCount_d;

    // Start-of-packet tracking: high when the next accepted beat opens a packet.
    logic        sop_q;
    logic        sop_d;

    // Output register, skid register and the registered ingress ready.
    beat_t       outBeat_q;
    beat_t       outBeat_d;
    logic        outValid_q;
    logic        outValid_d;
    beat_t       skidBeat_q;
    beat_t       skidBeat_d;
    logic        skidValid_q;
    logic        skidValid_d;
    logic        ready_q;
    logic        ready_d;

    // Ingress beat after stamping.
    logic                          acceptBeat;
    logic [C_AXIS_TUSER_WIDTH-1:0] stampedUser;
    beat_t                         inBeat;

`ifdef RX_TS_DELTA_EN
    // Timestamp captured at the previous SOP and whether it is meaningful.
    logic [31:0] prevSopTs_q;
    logic [31:0] prevSopTs_d;
    logic        deltaValid_q;
    logic        deltaValid_d;
    logic [31:0] deltaNow;
`endif

    assign acceptBeat = s_axis_tvalid && ready_q;

`ifdef RX_TS_DELTA_EN
    // Inter-arrival delta for a packet starting this cycle; zero when there is
    // no valid earlier SOP since reset or since the last counter load.
    always_comb begin
        deltaNow = 32'd0;
        if (deltaValid_q) begin
            deltaNow = tsCount_q[31:0] - prevSopTs_q;
        end
    end
`endif

    // Replace the timestamp field on the first beat of a packet; any other beat
    // keeps its tuser exactly as it arrived.
    always_comb begin
        stampedUser = s_axis_tuser;
        if (sop_q) begin
            stampedUser[TS_LSB+63:TS_LSB] = tsCount_q;
`ifdef RX_TS_DELTA_EN
            stampedUser[TS_LSB+95:TS_LSB+64] = deltaNow;
`endif
        end
    end

    assign inBeat = '{data: s_axis_tdata,
                      strb: s_axis_tstrb,
                      user: stampedUser,
                      last: s_axis_tlast};

    // Counter next-state: load wins over the per-cycle increment; packet
    // boundaries are tracked purely from accepted ingress beats.
    always_comb begin
        tsCount_d  = tsCount_q + {32'd0, TS_INC};
        sop_d      = sop_q;
        pktCount_d = pktCount_q;
        if (ts_load) begin
            tsCount_d = ts_load_value;
        end
        if (acceptBeat) begin
            sop_d = s_axis_tlast;
            if (s_axis_tlast) begin
                pktCount_d = pktCount_q + 32'd1;
            end
        end
    end

    // Output pipeline next-state. When the output register can advance, a
    // waiting skid beat always goes first so ordering is preserved; a beat that
    // arrives while the output is stalled parks in the skid, which in turn
    // drops ready for the following cycle.
    always_comb begin
        outBeat_d   = outBeat_q;
        outValid_d  = outValid_q;
        skidBeat_d  = skidBeat_q;
        skidValid_d = skidValid_q;
        if (!outValid_q || m_axis_tready) begin
            if (skidValid_q) begin
                outBeat_d   = skidBeat_q;
                outValid_d  = 1'b1;
                skidValid_d = 1'b0;
            end else if (acceptBeat) begin
                outBeat_d  = inBeat;
                outValid_d = 1'b1;
            end else begin
                outValid_d = 1'b0;
            end
        end else if (acceptBeat) begin
            skidBeat_d  = inBeat;
            skidValid_d = 1'b1;
        end
        ready_d = !skidValid_d;
    end

    // State registers for counters, SOP tracking and the output/skid pipeline.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            tsCount_q   <= 64'd0;
            pktCount_q  <= 32'd0;
            sop_q       <= 1'b1;
            outBeat_q   <= '0;
            outValid_q  <= 1'b0;
            skidBeat_q  <= '0;
            skidValid_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            tsCount_q   <= tsCount_d;
            pktCount_q  <= pktCount_d;
            sop_q       <= sop_d;
            outBeat_q   <= outBeat_d;
            outValid_q  <= outValid_d;
            skidBeat_q  <= skidBeat_d;
            skidValid_q <= skidValid_d;
            ready_q     <= ready_d;
        end
    end

`ifdef RX_TS_DELTA_EN
    // Remember the timestamp of each SOP; a counter load invalidates it so the
    // next packet reports a zero delta instead of a meaningless difference.
    always_comb begin
        prevSopTs_d  = prevSopTs_q;
        deltaValid_d = deltaValid_q;
        if (acceptBeat && sop_q) begin
            prevSopTs_d  = tsCount_q[31:0];
            deltaValid_d = 1'b1;
        end
        if (ts_load) begin
            deltaValid_d = 1'b0;
        end
    end

    // Delta bookkeeping registers.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            prevSopTs_q  <= 32'd0;
            deltaValid_q <= 1'b0;
        end else begin
            prevSopTs_q  <= prevSopTs_d;
            deltaValid_q <= deltaValid_d;
        end
    end
`endif

    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = outValid_q;
    assign m_axis_tdata  = outBeat_q.data;
    assign m_axis_tstrb  = outBeat_q.strb;
    assign m_axis_tuser  = outBeat_q.user;
    assign m_axis_tlast  = outBeat_q.last;
    assign ts_now        = tsCount_q;
    assign pkt_count     = pktCount_q;

endmodule

// File: tb/tb_nf10_rx_timestamp.sv
// tb_nf10_rx_timestamp
// Randomized scoreboard bench for nf10_rx_timestamp. The stimulus process
// drives packets and control pulses; a reference model observes the ingress
// handshake, predicts each egress beat from the stamping rules and queues it;
// the monitor compares the egress against the queue head every cycle.
// Define RX_TS_DELTA_EN for both files to cover the delta field.

module tb_nf10_rx_timestamp;

    localparam int          DW      = 256;
    localparam int          SW      = DW / 8;
    localparam int          UW      = 128;
    localparam int          TSL     = 32;
    localparam logic [63:0] TS_STEP = 64'd5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic          axi_aclk;
    logic          axi_resetn;
    logic [DW-1:0] s_axis_tdata;
    logic [SW-1:0] s_axis_tstrb;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [SW-1:0] m_axis_tstrb;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          ts_load;
    logic [63:0]   ts_load_value;
    logic [63:0]   ts_now;
    logic [31:0]   pkt_count;

    int          checks;
    int          failures;

    beat_t       expQ[$];
    logic [63:0] modelTs;
    logic        modelSop;
    logic [31:0] modelPkt;
    bit          firstAfterReset;
`ifdef RX_TS_DELTA_EN
    logic [31:0] modelPrevSop;
    bit          modelDeltaValid;
`endif

    int          readyPct;
    int          loadPct;
    int          stallCycles;
    bit          forceLoad;
    logic [63:0] forceLoadValue;

    nf10_rx_timestamp #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .TS_LSB            (TSL),
        .TS_INC            (32'h0000_0005)
    ) dut (
        .axi_aclk     (axi_aclk),
        .axi_resetn   (axi_resetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tstrb (s_axis_tstrb),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tstrb (m_axis_tstrb),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .ts_load      (ts_load),
        .ts_load_value(ts_load_value),
        .ts_now       (ts_now),
        .pkt_count    (pkt_count)
    );

    // Free-running 100 MHz-style clock for simulation.
    initial begin
        axi_aclk = 1'b0;
        forever #5 axi_aclk = ~axi_aclk;
    end

    task automatic checkOutput(input string name, input logic [511:0] actual,
                               input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [DW-1:0] randomData();
        logic [DW-1:0] r;
        for (int w = 0; w < DW / 32; w++) begin
            r[w*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    // Per-cycle egress ready and timestamp-load pulses.
    task automatic setControls();
        if (stallCycles > 0) begin
            m_axis_tready = 1'b0;
            stallCycles--;
        end else begin
            m_axis_tready = ($urandom_range(0, 99) < readyPct);
        end
        if (forceLoad) begin
            ts_load       = 1'b1;
            ts_load_value = forceLoadValue;
            forceLoad     = 1'b0;
        end else begin
            ts_load = ($urandom_range(0, 99) < loadPct);
            if ($urandom_range(0, 3) == 0) begin
                ts_load_value = {32'hFFFF_FFFF, 32'hFFFF_FF00 | $urandom_range(0, 255)};
            end else begin
                ts_load_value = {$urandom, $urandom};
            end
        end
    endtask

    // Present one beat and hold it until the DUT accepts it (bounded).
    task automatic applyStimulus(input logic [DW-1:0] data, input logic [SW-1:0] strb,
                                 input logic [UW-1:0] user, input logic last);
        bit done;
        bit hs;
        done          = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = data;
        s_axis_tstrb  = strb;
        s_axis_tuser  = user;
        s_axis_tlast  = last;
        for (int k = 0; k < 200 && !done; k++) begin
            setControls();
            @(negedge axi_aclk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge axi_aclk);
            #1;
            done = hs;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL handshake_timeout actual=no_accept required=accept");
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        s_axis_tvalid = 1'b0;
        for (int k = 0; k < n; k++) begin
            setControls();
            @(posedge axi_aclk);
            #1;
        end
    endtask

    task automatic sendPacket(input int len, input bit fixedUser, input logic [UW-1:0] user);
        for (int b = 0; b < len; b++) begin
            applyStimulus(randomData(), SW'($urandom),
                          fixedUser ? user : {$urandom, $urandom, $urandom, $urandom},
                          b == len - 1);
        end
    endtask

    // Reference model plus monitor. Inputs and outputs are stable at the
    // falling edge, so everything observed here describes the next rising edge.
    always @(negedge axi_aclk) begin : monitor
        beat_t got;
        beat_t exp;
        bit    accept;
        bit    deliver;
        if (!axi_resetn) begin
            checkOutput("reset_tvalid", m_axis_tvalid, 1'b0);
            checkOutput("reset_tready", s_axis_tready, 1'b0);
            checkOutput("reset_ts_now", ts_now, 64'd0);
            checkOutput("reset_pkt_count", pkt_count, 32'd0);
            checkOutput("reset_tuser", m_axis_tuser, '0);
            checkOutput("reset_tdata", m_axis_tdata, '0);
            expQ.delete();
            modelTs         = 64'd0;
            modelSop        = 1'b1;
            modelPkt        = 32'd0;
            firstAfterReset = 1'b1;
`ifdef RX_TS_DELTA_EN
            modelPrevSop    = 32'd0;
            modelDeltaValid = 1'b0;
`endif
        end else begin
            checkOutput("ts_now", ts_now, modelTs);
            checkOutput("pkt_count", pkt_count, modelPkt);
            checkOutput("tvalid", m_axis_tvalid, expQ.size() > 0);
            checkOutput("tready", s_axis_tready,
                        firstAfterReset ? 1'b0 : (expQ.size() < 2));

            got = '{data: m_axis_tdata, strb: m_axis_tstrb,
                    user: m_axis_tuser, last: m_axis_tlast};
            accept  = s_axis_tvalid && s_axis_tready;
            deliver = m_axis_tvalid && m_axis_tready;

            if (m_axis_tvalid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_beat actual=%0h required=none", got);
                end else if (m_axis_tready) begin
                    checkOutput("beat", got, expQ[0]);
                    void'(expQ.pop_front());
                end else begin
                    checkOutput("beat_hold", got, expQ[0]);
                end
            end

            if (accept) begin
                exp.data = s_axis_tdata;
                exp.strb = s_axis_tstrb;
                exp.user = s_axis_tuser;
                exp.last = s_axis_tlast;
                if (modelSop) begin
                    exp.user[TSL+63:TSL] = modelTs;
`ifdef RX_TS_DELTA_EN
                    exp.user[TSL+95:TSL+64] = modelDeltaValid ? (modelTs[31:0] - modelPrevSop) : 32'd0;
                    modelPrevSop    = modelTs[31:0];
                    modelDeltaValid = 1'b1;
`endif
                end
                expQ.push_back(exp);
                modelSop = s_axis_tlast;
                if (s_axis_tlast) begin
                    modelPkt = modelPkt + 32'd1;
                end
            end

            if (ts_load) begin
                modelTs = ts_load_value;
`ifdef RX_TS_DELTA_EN
                modelDeltaValid = 1'b0;
`endif
            end else begin
                modelTs = modelTs + TS_STEP;
            end
            firstAfterReset = 1'b0;
        end
    end

    // Directed scenarios first, then a randomized soak, then a bounded drain.
    initial begin
        checks         = 0;
        failures       = 0;
        axi_resetn     = 1'b0;
        s_axis_tvalid  = 1'b0;
        s_axis_tdata   = '0;
        s_axis_tstrb   = '0;
        s_axis_tuser   = '0;
        s_axis_tlast   = 1'b0;
        m_axis_tready  = 1'b0;
        ts_load        = 1'b0;
        ts_load_value  = 64'd0;
        readyPct       = 100;
        loadPct        = 0;
        stallCycles    = 0;
        forceLoad      = 1'b0;
        forceLoadValue = 64'd0;

        repeat (3) @(posedge axi_aclk);
        #1;
        axi_resetn = 1'b1;

        // Timestamp load followed by a 4-beat packet with a known tuser.
        forceLoad      = 1'b1;
        forceLoadValue = 64'h100;
        idleCycles(3);
        sendPacket(4, 1'b1, 128'h0201_0080);
        idleCycles(2);

        // Back-to-back single-beat packets at full rate.
        sendPacket(1, 1'b0, '0);
        for (int p = 0; p < 19; p++) begin
            sendPacket(1, 1'b0, '0);
        end
        idleCycles(2);

        // Egress stall in the middle of a packet.
        sendPacket(0, 1'b0, '0);
        applyStimulus(randomData(), SW'($urandom), 128'h1, 1'b0);
        applyStimulus(randomData(), SW'($urandom), 128'h2, 1'b0);
        stallCycles = 3;
        for (int b = 0; b < 4; b++) begin
            applyStimulus(randomData(), SW'($urandom), 128'h3 + UW'(b), b == 3);
        end
        idleCycles(3);

        // Counter wrap around 2^64.
        forceLoad      = 1'b1;
        forceLoadValue = 64'hFFFF_FFFF_FFFF_FFFA;
        idleCycles(4);
        sendPacket(2, 1'b0, '0);
        idleCycles(2);

        // Reset in the middle of a 5-beat packet.
        applyStimulus(randomData(), SW'($urandom), 128'h55, 1'b0);
        applyStimulus(randomData(), SW'($urandom), 128'h66, 1'b0);
        axi_resetn = 1'b0;
        repeat (2) @(posedge axi_aclk);
        #1;
        axi_resetn = 1'b1;
        idleCycles(1);
        sendPacket(3, 1'b0, '0);

        // Two SOPs twenty cycles apart (exercises the delta field when built).
        sendPacket(1, 1'b0, '0);
        idleCycles(19);
        sendPacket(1, 1'b0, '0);
        idleCycles(2);

        // Randomized soak with egress backpressure and occasional loads.
        readyPct = 65;
        loadPct  = 3;
        for (int p = 0; p < 300; p++) begin
            sendPacket($urandom_range(1, 6), 1'b0, '0);
            if ($urandom_range(0, 3) == 0) begin
                idleCycles($urandom_range(1, 3));
            end
        end

        // Drain everything still in flight.
        readyPct = 100;
        loadPct  = 0;
        for (int k = 0; k < 100 && expQ.size() > 0; k++) begin
            idleCycles(1);
        end
        idleCycles(2);
        checkOutput("drain_empty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
